// File: rtl/time_entry.sv
// time_entry: keypad-entered M:SS countdown timer.
//   Digits are keyed in shift-left style while in ENTRY, START counts the
//   value down once per sec_tick, STOP pauses, and CLEAR returns to 0:00.
// Ports:
//   clk       in   rising-edge clock for all state
//   rst_n     in   synchronous active-low reset
//   key_valid in   one-cycle strobe qualifying key_code
//   key_code  in   [3:0] 0-9 digit, 10 CLEAR, 11 START, 12 STOP, 13-15 reserved
//   sec_tick  in   one-cycle 1 Hz pulse
//   min       out  [3:0] BCD minutes digit
//   sec_tens  out  [3:0] BCD tens-of-seconds digit
//   sec_ones  out  [3:0] BCD seconds digit
//   running   out  high while counting down
//   paused    out  high while paused
//   done      out  one-cycle pulse when the countdown reaches 0:00
module time_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       sec_tick,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       done
);

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] min_nxt, tens_nxt, ones_nxt;
  logic       done_nxt;

  logic key_digit, key_clear, key_start, key_stop;
  logic value_zero, value_one;

  assign key_digit  = key_valid && (key_code <= 4'd9);
  assign key_clear  = key_valid && (key_code == 4'd10);
  assign key_start  = key_valid && (key_code == 4'd11);
  assign key_stop   = key_valid && (key_code == 4'd12);

  assign value_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign value_one  = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  always_comb begin
    state_nxt = state;
    min_nxt   = min;
    tens_nxt  = sec_tens;
    ones_nxt  = sec_ones;
    done_nxt  = 1'b0;

    unique case (state)
      ENTRY: begin
        if (key_digit) begin
          // Shift is refused when the incoming tens digit would exceed 5.
          if (sec_ones <= 4'd5) begin
            min_nxt  = sec_tens;
            tens_nxt = sec_ones;
            ones_nxt = key_code;
          end
        end else if (key_clear) begin
          min_nxt  = '0;
          tens_nxt = '0;
          ones_nxt = '0;
        end else if (key_start && !value_zero) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        // STOP and CLEAR take priority and swallow a coincident tick.
        if (key_stop) begin
          state_nxt = PAUSE;
        end else if (key_clear) begin
          min_nxt   = '0;
          tens_nxt  = '0;
          ones_nxt  = '0;
          state_nxt = ENTRY;
        end else if (sec_tick) begin
          if (value_one) begin
            ones_nxt  = '0;
            done_nxt  = 1'b1;
            state_nxt = ENTRY;
          end else if (sec_ones != 4'd0) begin
            ones_nxt = sec_ones - 4'd1;
          end else begin
            ones_nxt = 4'd9;
            if (sec_tens != 4'd0) begin
              tens_nxt = sec_tens - 4'd1;
            end else begin
              tens_nxt = 4'd5;
              min_nxt  = min - 4'd1;
            end
          end
        end
      end

      PAUSE: begin
        if (key_start) begin
          state_nxt = RUN;
        end else if (key_clear || key_stop) begin
          min_nxt   = '0;
          tens_nxt  = '0;
          ones_nxt  = '0;
          state_nxt = ENTRY;
        end
      end

      default: begin
        state_nxt = ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ENTRY;
      min      <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      running  <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      min      <= min_nxt;
      sec_tens <= tens_nxt;
      sec_ones <= ones_nxt;
      // Status flags are registered copies of the next state so they
      // change on the same edge as the state itself.
      running  <= (state_nxt == RUN);
      paused   <= (state_nxt == PAUSE);
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: directed self-checking bench for time_entry.
module tb_time_entry;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       sec_tick;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       paused;
  logic       done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [3:0] K_CLEAR = 4'd10;
  localparam logic [3:0] K_START = 4'd11;
  localparam logic [3:0] K_STOP  = 4'd12;

  time_entry dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .sec_tick  (sec_tick),
    .min       (min),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .paused    (paused),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic step(input logic kv, input logic [3:0] kc, input logic tk);
    key_valid = kv;
    key_code  = kc;
    sec_tick  = tk;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    sec_tick  = 1'b0;
  endtask

  task automatic key(input logic [3:0] kc);
    step(1'b1, kc, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 4'd0, 1'b1);
  endtask

  task automatic check_val(input string tag, input logic [11:0] exp);
    check(tag, {20'd0, min, sec_tens, sec_ones}, {20'd0, exp});
  endtask

  task automatic check_flags(input string tag, input logic r, input logic p, input logic d);
    check(tag, {29'd0, running, paused, done}, {29'd0, r, p, d});
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    sec_tick  = 1'b0;
    #1;

    // Reset overrides a coincident digit key.
    step(1'b1, 4'd5, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    check_val("reset_val", 12'h000);
    check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // First key after release is accepted.
    key(4'd1);
    check_val("first_key", 12'h001);
    key(4'd3); key(4'd0);
    check_val("enter_130", 12'h130);
    key(4'd7);
    check_val("shift_307", 12'h307);

    key(K_CLEAR);
    check_val("entry_clear", 12'h000);
    key(4'd0); key(4'd7);
    check_val("enter_007", 12'h007);
    key(4'd4);
    check_val("reject_gt5", 12'h007);
    key(4'd13);
    check_val("reserved_13", 12'h007);
    step(1'b0, 4'd5, 1'b0);
    check_val("kv_low", 12'h007);
    key(K_STOP);
    check_val("entry_stop", 12'h007);
    check_flags("entry_stop_flags", 1'b0, 1'b0, 1'b0);
    tick();
    check_val("entry_tick", 12'h007);

    // START at 0:00 is ignored.
    key(K_CLEAR);
    key(K_START);
    check_flags("start_zero", 1'b0, 1'b0, 1'b0);

    // Full 1:00 countdown.
    key(4'd1); key(4'd0); key(4'd0);
    check_val("enter_100", 12'h100);
    key(K_START);
    check_flags("run_start", 1'b1, 1'b0, 1'b0);
    tick();
    check_val("tick_059", 12'h059);
    check_flags("tick_059_flags", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 58; i++) tick();
    check_val("at_001", 12'h001);
    check_flags("at_001_flags", 1'b1, 1'b0, 1'b0);
    tick();
    check_val("terminal_val", 12'h000);
    check_flags("terminal_flags", 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0);
    check_flags("done_one_cycle", 1'b0, 1'b0, 1'b0);

    // Pause behaviour at 0:45.
    key(4'd4); key(4'd5);
    key(K_START);
    step(1'b1, K_STOP, 1'b1);
    check_val("stop_tick_val", 12'h045);
    check_flags("stop_tick_flags", 1'b0, 1'b1, 1'b0);
    tick();
    check_val("pause_tick", 12'h045);
    key(4'd2);
    check_val("pause_digit", 12'h045);
    key(K_START);
    check_flags("resume_flags", 1'b1, 1'b0, 1'b0);
    tick();
    check_val("resume_044", 12'h044);
    step(1'b1, 4'd3, 1'b1);
    check_val("run_digit_tick", 12'h043);
    step(1'b1, K_START, 1'b1);
    check_val("run_start_tick", 12'h042);
    check_flags("run_start_tick_flags", 1'b1, 1'b0, 1'b0);
    key(K_STOP);
    key(K_STOP);
    check_val("pause_stop_val", 12'h000);
    check_flags("pause_stop_flags", 1'b0, 1'b0, 1'b0);

    // CLEAR during RUN at 2:10, with a coincident tick.
    key(4'd2); key(4'd1); key(4'd0);
    key(K_START);
    step(1'b1, K_CLEAR, 1'b1);
    check_val("run_clear_val", 12'h000);
    check_flags("run_clear_flags", 1'b0, 1'b0, 1'b0);

    // Minute borrow: 2:00 -> 1:59.
    key(4'd2); key(4'd0); key(4'd0);
    key(K_START);
    tick();
    check_val("borrow_159", 12'h159);
    key(K_STOP);
    key(K_CLEAR);
    check_val("pause_clear", 12'h000);

    // Reset mid-RUN at 0:01 coincident with the terminal tick.
    key(4'd2);
    key(K_START);
    tick();
    check_val("pre_reset_001", 12'h001);
    rst_n = 1'b0;
    step(1'b0, 4'd0, 1'b1);
    check_val("reset_run_val", 12'h000);
    check_flags("reset_run_flags", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    check_flags("post_reset_flags", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
